// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle port-A results and FIFO-buffered port-B load
// returns into one registered register-file write per cycle, with a pending-write mask.
module wb_arbiter #(
  parameter int unsigned B_DEPTH  = 4,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_a_valid,
  output logic        o_a_ready,
  input  logic [0:5]  i_a_addr,
  input  logic [0:2]  i_a_ppp,
  input  logic [0:63] i_a_data,
  input  logic        i_b_valid,
  output logic        o_b_ready,
  input  logic [0:5]  i_b_addr,
  input  logic [0:2]  i_b_ppp,
  input  logic [0:63] i_b_data,
  output logic        o_wb_en,
  output logic [0:2]  o_wb_ppp,
  output logic [0:5]  o_wb_addr,
  output logic [0:63] o_wb_data,
  output logic [0:31] o_pend_mask,
  output logic        o_wb_err
);

  localparam int unsigned PtrW  = $clog2(B_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned WaitW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0]  Depth   = CntW'(B_DEPTH);
  localparam logic [WaitW-1:0] MaxWait = WaitW'(MAX_WAIT);

  typedef struct packed {
    logic [0:5]  addr;
    logic [0:2]  ppp;
    logic [0:63] data;
  } entry_t;

  entry_t             r_mem [B_DEPTH];
  logic [B_DEPTH-1:0] r_vld;
  logic [PtrW-1:0]    r_wr_ptr;
  logic [PtrW-1:0]    r_rd_ptr;
  logic [CntW-1:0]    r_count;
  logic [WaitW-1:0]   r_wait;

  logic        r_wb_en;
  logic        r_wb_err;
  logic [0:2]  r_wb_ppp;
  logic [0:5]  r_wb_addr;
  logic [0:63] r_wb_data;

  logic   w_nonempty;
  logic   w_force_b;
  logic   w_grant_a;
  logic   w_grant_b;
  logic   w_grant;
  logic   w_push;
  entry_t w_sel;
  logic   w_sel_zero;
  logic   w_sel_legal;

  // Register 0 is checked separately: it is a silent drop, not an error.
  function automatic logic f_legal(input logic [0:5] addr, input logic [0:2] ppp);
    return (ppp <= 3'd4) && !addr[0] && (addr != 6'd0);
  endfunction

  assign w_nonempty  = (r_count != '0);
  assign w_force_b   = w_nonempty && (r_wait >= MaxWait);
  assign o_a_ready   = !rst && !w_force_b;
  assign o_b_ready   = !rst && (r_count < Depth);
  assign w_grant_a   = i_a_valid && o_a_ready;
  assign w_grant_b   = !rst && !w_grant_a && w_nonempty;
  assign w_grant     = w_grant_a || w_grant_b;
  assign w_push      = i_b_valid && o_b_ready;
  assign w_sel       = w_grant_a ? {i_a_addr, i_a_ppp, i_a_data} : r_mem[r_rd_ptr];
  assign w_sel_zero  = (w_sel.addr == 6'd0);
  assign w_sel_legal = f_legal(w_sel.addr, w_sel.ppp);

  always_comb begin
    o_pend_mask = '0;
    for (int unsigned i = 0; i < B_DEPTH; i++) begin
      if (r_vld[i] && f_legal(r_mem[i].addr, r_mem[i].ppp)) begin
        o_pend_mask[r_mem[i].addr[1:5]] = 1'b1;
      end
    end
    if (r_wb_en) begin
      o_pend_mask[r_wb_addr[1:5]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_b_addr, i_b_ppp, i_b_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_vld     <= '0;
      r_wait    <= '0;
      r_wb_en   <= 1'b0;
      r_wb_err  <= 1'b0;
      r_wb_ppp  <= '0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_vld[r_wr_ptr] <= 1'b1;
      end
      if (w_grant_b) begin
        r_rd_ptr        <= r_rd_ptr + 1'b1;
        r_vld[r_rd_ptr] <= 1'b0;
      end
      case ({w_push, w_grant_b})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Counts how many times a waiting head was bypassed by port A.
      if (w_grant_b || !w_nonempty) begin
        r_wait <= '0;
      end else if (w_grant_a && (r_wait < MaxWait)) begin
        r_wait <= r_wait + 1'b1;
      end
      r_wb_en  <= w_grant && w_sel_legal;
      r_wb_err <= w_grant && !w_sel_zero && !w_sel_legal;
      if (w_grant) begin
        r_wb_ppp  <= w_sel.ppp;
        r_wb_addr <= w_sel.addr;
        r_wb_data <= w_sel.data;
      end
    end
  end

  assign o_wb_en   = r_wb_en;
  assign o_wb_err  = r_wb_err;
  assign o_wb_ppp  = r_wb_ppp;
  assign o_wb_addr = r_wb_addr;
  assign o_wb_data = r_wb_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle, plus directed
// literal expectations for reset, latency, FIFO fill/drain, starvation and illegal writes.
module tb_wb_arbiter;

  localparam int unsigned BDepth  = 4;
  localparam int unsigned MaxWait = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [0:5]  a_addr, b_addr;
  logic [0:2]  a_ppp, b_ppp;
  logic [0:63] a_data, b_data;
  logic        wb_en, wb_err;
  logic [0:2]  wb_ppp;
  logic [0:5]  wb_addr;
  logic [0:63] wb_data;
  logic [0:31] pend_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .B_DEPTH (BDepth),
    .MAX_WAIT(MaxWait)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_a_valid  (a_valid),
    .o_a_ready  (a_ready),
    .i_a_addr   (a_addr),
    .i_a_ppp    (a_ppp),
    .i_a_data   (a_data),
    .i_b_valid  (b_valid),
    .o_b_ready  (b_ready),
    .i_b_addr   (b_addr),
    .i_b_ppp    (b_ppp),
    .i_b_data   (b_data),
    .o_wb_en    (wb_en),
    .o_wb_ppp   (wb_ppp),
    .o_wb_addr  (wb_addr),
    .o_wb_data  (wb_data),
    .o_pend_mask(pend_mask),
    .o_wb_err   (wb_err)
  );

  typedef struct packed {
    logic [0:5]  addr;
    logic [0:2]  ppp;
    logic [0:63] data;
  } ent_t;

  // Reference model state: the FIFO as a queue, the bypass count as a plain integer.
  ent_t        q[$];
  int          m_wait;
  logic        m_en, m_err;
  logic [0:5]  m_addr;
  logic [0:2]  m_ppp;
  logic [0:63] m_data;

  function automatic bit is_legal(logic [0:5] a, logic [0:2] p);
    return (p <= 3'd4) && (a < 6'd32) && (a != 6'd0);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   n;
    bit   force_b, ga, gb, push;
    ent_t sel;
    m_wait = 0; m_en = 0; m_err = 0; m_addr = '0; m_ppp = '0; m_data = '0;
    sel = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_wait = 0; m_en = 0; m_err = 0; m_addr = '0; m_ppp = '0; m_data = '0;
      end else begin
        n       = q.size();
        force_b = (n > 0) && (m_wait >= MaxWait);
        ga      = a_valid && !force_b;
        gb      = !ga && (n > 0);
        push    = b_valid && (n < BDepth);
        if (ga) sel = {a_addr, a_ppp, a_data};
        else if (gb) sel = q.pop_front();
        if (gb || n == 0) m_wait = 0;
        else if (ga && m_wait < MaxWait) m_wait = m_wait + 1;
        if (ga || gb) begin
          m_en   = is_legal(sel.addr, sel.ppp);
          m_err  = (sel.addr != 6'd0) && !is_legal(sel.addr, sel.ppp);
          m_addr = sel.addr;
          m_ppp  = sel.ppp;
          m_data = sel.data;
        end else begin
          m_en  = 0;
          m_err = 0;
        end
        if (push) q.push_back({b_addr, b_ppp, b_data});
      end
    end
  end

  initial begin
    logic [0:31] em;
    bit          ea, eb;
    @(posedge clk);
    forever begin
      @(negedge clk);
      em = '0;
      foreach (q[j]) if (is_legal(q[j].addr, q[j].ppp)) em[q[j].addr[1:5]] = 1'b1;
      if (m_en) em[m_addr[1:5]] = 1'b1;
      ea = !rst && !((q.size() > 0) && (m_wait >= MaxWait));
      eb = !rst && (q.size() < BDepth);
      check("m_a_ready", 64'(a_ready), 64'(ea));
      check("m_b_ready", 64'(b_ready), 64'(eb));
      check("m_wb_en", 64'(wb_en), 64'(m_en));
      check("m_wb_err", 64'(wb_err), 64'(m_err));
      check("m_pend_mask", 64'(pend_mask), 64'(em));
      if (m_en) begin
        check("m_wb_addr", 64'(wb_addr), 64'(m_addr));
        check("m_wb_ppp", 64'(wb_ppp), 64'(m_ppp));
        check("m_wb_data", wb_data, m_data);
      end
    end
  end

  initial begin
    logic [0:31] e;
    rst = 1; a_valid = 1; a_addr = 6'd3; a_ppp = 3'd0; a_data = 64'h1;
    b_valid = 1; b_addr = 6'd2; b_ppp = 3'd0; b_data = 64'h2;

    // Reset held two cycles with both sources valid.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_a_ready", 64'(a_ready), 64'd0);
      check("rst_b_ready", 64'(b_ready), 64'd0);
      check("rst_wb_en", 64'(wb_en), 64'd0);
      check("rst_pend", 64'(pend_mask), 64'd0);
    end
    rst = 0; a_valid = 0; b_valid = 0;
    #1;
    check("rel_b_ready", 64'(b_ready), 64'd1);
    check("rel_a_ready", 64'(a_ready), 64'd1);
    check("rel_wb_addr", 64'(wb_addr), 64'd0);
    check("rel_wb_data", wb_data, 64'd0);
    check("rel_model_q", 64'(q.size()), 64'd0);

    // Port A single write, one-cycle latency, then hold.
    a_valid = 1; a_addr = 6'd5; a_ppp = 3'd0; a_data = 64'hDEAD_BEEF_0123_4567;
    tick();
    a_valid = 0;
    check("a_wb_en", 64'(wb_en), 64'd1);
    check("a_wb_addr", 64'(wb_addr), 64'd5);
    check("a_wb_ppp", 64'(wb_ppp), 64'd0);
    check("a_wb_data", wb_data, 64'hDEAD_BEEF_0123_4567);
    e = '0; e[5] = 1'b1;
    check("a_pend", 64'(pend_mask), 64'(e));
    tick();
    check("a_idle_wb_en", 64'(wb_en), 64'd0);
    check("a_hold_addr", 64'(wb_addr), 64'd5);
    check("a_hold_data", wb_data, 64'hDEAD_BEEF_0123_4567);

    // Fill FIFO with regs 1..4 while port A keeps it busy with silent reg-0 writes.
    a_valid = 1; a_addr = 6'd0; a_ppp = 3'd0; b_valid = 1; b_ppp = 3'd0;
    for (int i = 1; i <= 4; i++) begin
      b_addr = 6'(i); b_data = 64'h100 + 64'(i);
      tick();
    end
    a_valid = 0; b_valid = 0;
    check("fill_model_q", 64'(q.size()), 64'd4);
    check("fill_b_ready", 64'(b_ready), 64'd0);
    check("fill_a_ready", 64'(a_ready), 64'd0);
    check("fill_zero_en", 64'(wb_en), 64'd0);
    check("fill_zero_err", 64'(wb_err), 64'd0);
    e = '0; e[1] = 1'b1; e[2] = 1'b1; e[3] = 1'b1; e[4] = 1'b1;
    check("fill_pend", 64'(pend_mask), 64'(e));
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("drain_wb_en", 64'(wb_en), 64'd1);
      check("drain_wb_addr", 64'(wb_addr), 64'(i));
      check("drain_wb_data", wb_data, 64'h100 + 64'(i));
      e = '0;
      for (int k = i; k <= 4; k++) e[k] = 1'b1;
      check("drain_pend", 64'(pend_mask), 64'(e));
    end
    tick();
    check("drain_done_en", 64'(wb_en), 64'd0);
    check("drain_done_pend", 64'(pend_mask), 64'd0);

    // Starvation: reg 7 waits behind three port-A grants, then is forced.
    a_valid = 1; a_addr = 6'd10; a_ppp = 3'd0; a_data = 64'hA;
    b_valid = 1; b_addr = 6'd7; b_ppp = 3'd1; b_data = 64'h77;
    tick();
    b_valid = 0;
    for (int k = 0; k < 3; k++) begin
      check("starve_a_ready", 64'(a_ready), 64'd1);
      tick();
      check("starve_a_addr", 64'(wb_addr), 64'd10);
    end
    check("starve_forced", 64'(a_ready), 64'd0);
    tick();
    check("starve_b_en", 64'(wb_en), 64'd1);
    check("starve_b_addr", 64'(wb_addr), 64'd7);
    check("starve_b_ppp", 64'(wb_ppp), 64'd1);
    check("starve_a_back", 64'(a_ready), 64'd1);
    tick();
    check("starve_a_again", 64'(wb_addr), 64'd10);
    a_valid = 0;
    tick();

    // Illegal lane code through the FIFO, then illegal/zero writes through port A.
    b_valid = 1; b_addr = 6'd9; b_ppp = 3'b110; b_data = 64'h99;
    tick();
    b_valid = 0;
    check("ill_pend", 64'(pend_mask), 64'd0);
    tick();
    check("ill_b_err", 64'(wb_err), 64'd1);
    check("ill_b_en", 64'(wb_en), 64'd0);
    check("ill_b_pend", 64'(pend_mask), 64'd0);
    tick();
    check("ill_err_pulse", 64'(wb_err), 64'd0);
    a_valid = 1; a_addr = 6'd40; a_ppp = 3'd0;
    tick();
    check("ill_a_hi_err", 64'(wb_err), 64'd1);
    a_addr = 6'd12; a_ppp = 3'b101;
    tick();
    check("ill_a_ppp_err", 64'(wb_err), 64'd1);
    check("ill_a_ppp_en", 64'(wb_en), 64'd0);
    a_addr = 6'd0; a_ppp = 3'b000;
    tick();
    check("zero_a_err", 64'(wb_err), 64'd0);
    check("zero_a_en", 64'(wb_en), 64'd0);
    a_valid = 0;
    tick();

    // Mid-operation reset with three queued entries.
    a_valid = 1; a_addr = 6'd0; b_valid = 1; b_ppp = 3'd2;
    for (int i = 11; i <= 13; i++) begin
      b_addr = 6'(i); b_data = 64'(i);
      tick();
    end
    a_valid = 0; b_valid = 0;
    check("mid_model_q", 64'(q.size()), 64'd3);
    e = '0; e[11] = 1'b1; e[12] = 1'b1; e[13] = 1'b1;
    check("mid_pend", 64'(pend_mask), 64'(e));
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("mid_pend_clr", 64'(pend_mask), 64'd0);
    check("mid_b_ready", 64'(b_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_no_wb", 64'(wb_en), 64'd0);
    end

    // Mixed traffic against the model, then drain.
    for (int k = 0; k < 80; k++) begin
      a_valid = 1'($urandom_range(0, 1));
      a_addr  = 6'($urandom_range(0, 40));
      a_ppp   = 3'($urandom_range(0, 5));
      a_data  = {$urandom, $urandom};
      b_valid = 1'($urandom_range(0, 1));
      b_addr  = 6'($urandom_range(0, 40));
      b_ppp   = 3'($urandom_range(0, 5));
      b_data  = {$urandom, $urandom};
      tick();
    end
    a_valid = 0; b_valid = 0;
    for (int k = 0; k < 8; k++) tick();
    check("end_pend", 64'(pend_mask), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
